// File: rtl/bus_arbiter.sv
// Four-requester round-robin bus arbiter with hold limit and forced release.
// Define BUS_ARB_TURNAROUND_EN to insert a one-cycle bus-idle TURN state between owners.
module bus_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_req,
  output logic [3:0] o_gnt,
  output logic [1:0] o_gnt_id,
  output logic       o_bus_busy,
  output logic       o_preempt
);

  // state | meaning
  // IDLE  | no owner, arbitrate every edge
  // GRANT | owner holds bus, hold counter running
  // TURN  | one bus-idle cycle between owners (turnaround build only)
`ifdef BUS_ARB_TURNAROUND_EN
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_TURN} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT} state_t;
`endif

  localparam logic [3:0] LP_MAX = 4'(MAX_HOLD);

  state_t     r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_gnt_id;
  logic [1:0] r_last_id;
  logic       r_busy;
  logic       r_preempt;
  logic [3:0] r_hold_cnt;

  logic [1:0] w_win_id;
  logic [3:0] w_win_oh;
  logic       w_win_any;
  logic       w_vol;
  logic       w_at_max;
  logic       w_others;
  logic       w_forced;

  // Scan from lowest to highest priority so the nearest requester after last_id wins.
  always_comb begin
    w_win_id = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      if (i_req[r_last_id + 2'(k)]) w_win_id = r_last_id + 2'(k);
    end
  end

  assign w_win_oh  = 4'b0001 << w_win_id;
  assign w_win_any = |i_req;
  assign w_vol     = ~|(i_req & r_gnt);
  assign w_at_max  = (r_hold_cnt == LP_MAX);
  assign w_others  = |(i_req & ~r_gnt);
  assign w_forced  = !w_vol && w_at_max && w_others;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_gnt      <= 4'd0;
      r_gnt_id   <= 2'd0;
      r_last_id  <= 2'd3;
      r_busy     <= 1'b0;
      r_preempt  <= 1'b0;
      r_hold_cnt <= 4'd0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_any) begin
            r_state    <= ST_GRANT;
            r_gnt      <= w_win_oh;
            r_gnt_id   <= w_win_id;
            r_last_id  <= w_win_id;
            r_busy     <= 1'b1;
            r_hold_cnt <= 4'd1;
          end
        end
        ST_GRANT: begin
          if (w_vol || w_forced) begin
            r_preempt  <= w_forced;
            r_hold_cnt <= 4'd0;
`ifdef BUS_ARB_TURNAROUND_EN
            r_state    <= ST_TURN;
            r_gnt      <= 4'd0;
            r_busy     <= 1'b0;
`else
            // last_id is still the old owner, so it is searched last here.
            if (w_win_any) begin
              r_state    <= ST_GRANT;
              r_gnt      <= w_win_oh;
              r_gnt_id   <= w_win_id;
              r_last_id  <= w_win_id;
              r_busy     <= 1'b1;
              r_hold_cnt <= 4'd1;
            end else begin
              r_state <= ST_IDLE;
              r_gnt   <= 4'd0;
              r_busy  <= 1'b0;
            end
`endif
          end else if (!w_at_max) begin
            r_hold_cnt <= r_hold_cnt + 4'd1;
          end
        end
`ifdef BUS_ARB_TURNAROUND_EN
        ST_TURN: begin
          if (w_win_any) begin
            r_state    <= ST_GRANT;
            r_gnt      <= w_win_oh;
            r_gnt_id   <= w_win_id;
            r_last_id  <= w_win_id;
            r_busy     <= 1'b1;
            r_hold_cnt <= 4'd1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 4'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt      = r_gnt;
  assign o_gnt_id   = r_gnt_id;
  assign o_bus_busy = r_busy;
  assign o_preempt  = r_preempt;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a behavioural owner/queue model predicts each cycle.
// Follows BUS_ARB_TURNAROUND_EN the same way as the design build.
module tb_bus_arbiter;
  localparam int MAX_HOLD = 8;
  localparam int STARVE_LIMIT = 3 * (MAX_HOLD + 1);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'd0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       bus_busy;
  logic       preempt;

  bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .i_clk(clk), .i_reset(reset), .i_req(req),
    .o_gnt(gnt), .o_gnt_id(gnt_id), .o_bus_busy(bus_busy), .o_preempt(preempt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] gid;
    logic       busy;
    logic       pre;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Model: who owns the bus (-1 none), how long, who was granted last.
  int m_owner = -1;
  int m_hold  = 0;
  int m_last  = 3;
  int m_gid   = 0;
  bit m_pre   = 1'b0;
  bit m_gap   = 1'b0;

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic take_bus(input logic [3:0] r);
    int w;
    w = rr_pick(r, m_last);
    if (w >= 0) begin
      m_owner = w;
      m_last  = w;
      m_gid   = w;
      m_hold  = 1;
    end
  endtask

  task automatic model_step(input bit rst, input logic [3:0] r);
    bit vol, forced;
    if (rst) begin
      m_owner = -1; m_hold = 0; m_last = 3; m_gid = 0; m_pre = 1'b0; m_gap = 1'b0;
      return;
    end
    m_pre = 1'b0;
    if (m_owner >= 0) begin
      vol    = !r[m_owner];
      forced = !vol && (m_hold == MAX_HOLD) && ((r & ~(4'b0001 << m_owner)) != 4'd0);
      if (vol || forced) begin
        m_pre   = forced;
        m_owner = -1;
        m_hold  = 0;
`ifdef BUS_ARB_TURNAROUND_EN
        m_gap = 1'b1;
`else
        take_bus(r);
`endif
      end else if (m_hold < MAX_HOLD) begin
        m_hold++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
      take_bus(r);
    end else begin
      take_bus(r);
    end
  endtask

  task automatic drive(input bit rst, input logic [3:0] r);
    exp_t e;
    @(negedge clk);
    reset = rst;
    req   = r;
    model_step(rst, r);
    e.gnt  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'd0;
    e.gid  = 2'(m_gid);
    e.busy = (m_owner >= 0);
    e.pre  = m_pre;
    sb_q.push_back(e);
  endtask

  task automatic expect_now(input string name, input logic [3:0] g, input logic [1:0] id,
                            input logic b, input logic p);
    @(posedge clk);
    #2;
    n_checks++;
    if (gnt !== g || gnt_id !== id || bus_busy !== b || preempt !== p) begin
      n_errors++;
      $display("FAIL %s: got gnt=%b id=%0d busy=%b pre=%b, want gnt=%b id=%0d busy=%b pre=%b",
               name, gnt, gnt_id, bus_busy, preempt, g, id, b, p);
    end
  endtask

  // Monitor: pops one expected response per cycle and checks the invariants.
  int wait_cnt[4] = '{0, 0, 0, 0};
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if ({gnt, gnt_id, bus_busy, preempt} !== e) begin
          n_errors++;
          $display("FAIL cycle t=%0t: got gnt=%b id=%0d busy=%b pre=%b, want gnt=%b id=%0d busy=%b pre=%b",
                   $time, gnt, gnt_id, bus_busy, preempt, e.gnt, e.gid, e.busy, e.pre);
        end
        n_checks++;
        if (!$onehot0(gnt) || bus_busy !== (|gnt)) begin
          n_errors++;
          $display("FAIL invariant t=%0t: gnt=%b busy=%b, want onehot0 gnt and busy=%b",
                   $time, gnt, bus_busy, |gnt);
        end
        for (int i = 0; i < 4; i++) begin
          if (!reset && req[i] && !gnt[i]) wait_cnt[i]++;
          else wait_cnt[i] = 0;
          n_checks++;
          if (wait_cnt[i] > STARVE_LIMIT) begin
            n_errors++;
            $display("FAIL starve req%0d t=%0t: waited %0d cycles, limit %0d",
                     i, $time, wait_cnt[i], STARVE_LIMIT);
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] r;

    // Reset then 4'b0101 held: requester 0 first.
    repeat (3) drive(1'b1, 4'b0101);
    drive(1'b0, 4'b0101);
    expect_now("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    repeat (20) drive(1'b0, 4'b0101);

    // All four requesting: hold limit rotation 0,1,2,3,0.
    repeat (2) drive(1'b1, 4'b0000);
    repeat (45) drive(1'b0, 4'b1111);

    // Sole requester keeps the bus with no preemption.
    repeat (2) drive(1'b1, 4'b0000);
    repeat (30) drive(1'b0, 4'b0100);

    // Owner 1 drops while requester 3 rises on the same edge.
    repeat (2) drive(1'b1, 4'b0000);
    drive(1'b0, 4'b0010);
    expect_now("own1_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    drive(1'b0, 4'b0010);
    drive(1'b0, 4'b1000);
`ifdef BUS_ARB_TURNAROUND_EN
    expect_now("swap_turn", 4'b0000, 2'd1, 1'b0, 1'b0);
    drive(1'b0, 4'b1000);
`endif
    expect_now("swap_new", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Reset mid-grant, then restart with 4'b0110.
    repeat (2) drive(1'b1, 4'b0000);
    drive(1'b0, 4'b0100);
    expect_now("own2_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    drive(1'b0, 4'b0100);
    drive(1'b1, 4'b0100);
    expect_now("mid_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    drive(1'b0, 4'b0110);
    expect_now("after_reset", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Random level requests with mostly sticky bits.
    r = 4'b0000;
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      end
      if ($urandom_range(99) == 0) r = 4'($urandom);
      drive(1'b0, r);
    end

    repeat (3) @(posedge clk);
    #3;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected responses left, want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
